// File: rtl/sequenciador_programa.sv
// Program sequencer for the multicycle processor.
// Holds a short program in a local word buffer and issues it one instruction
// at a time on DIN/Run, waiting for Done between issues. mvi is two words:
// the immediate is presented on DIN in the cycle after issue and held until
// Done. A watchdog aborts the run when Done never shows up.
module sequenciador_programa #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 7
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [15:0]   WrData,
  input  logic [AW:0]   ProgLen,
  input  logic          Start,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Finished,
  output logic          Error
);

  localparam int             AX      = AW + 1;
  localparam int             WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0]     OP_MVI  = 3'b001;
  localparam logic [AW:0]    X_ONE   = AX'(1);
  localparam logic [AW:0]    X_TWO   = AX'(2);
  localparam logic [AW:0]    LEN_MAX = AX'(DEPTH);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_t;

  logic [15:0] mem [DEPTH];

  state_t         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [AW:0]    len_q, len_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           mvi_q, mvi_d;
  logic           trunc_q, trunc_d;
  logic [15:0]    din_q, din_d;
  logic           run_q, run_d;
  logic           busy_q, busy_d;
  logic           fin_q, fin_d;
  logic           err_q, err_d;

  logic           go_issue;
  logic [AW:0]    tgt_pc, tgt_len, nxt_pc, start_len;
  logic [15:0]    tgt_word;
  logic           tgt_mvi;

  // Program buffer: writable only while idle, deliberately not reset.
  always_ff @(posedge Clock) begin
    if (WrEn && (state_q == S_IDLE)) mem[WrAddr] <= WrData;
  end

  // Next-state logic; every output is computed for the state being entered
  // so the registered outputs line up with the state they belong to.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    wd_d     = wd_q;
    mvi_d    = mvi_q;
    trunc_d  = trunc_q;
    din_d    = din_q;
    err_d    = err_q;
    go_issue = 1'b0;
    tgt_pc   = '0;
    tgt_len  = len_q;
    tgt_word = '0;
    tgt_mvi  = 1'b0;
    // PC arithmetic at AW+1 bits so stepping past the last word never wraps.
    nxt_pc    = {1'b0, pc_q} + (mvi_q ? X_TWO : X_ONE);
    start_len = (ProgLen > LEN_MAX) ? LEN_MAX : ProgLen;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          len_d = start_len;
          pc_d  = '0;
          err_d = 1'b0;
          if (start_len == '0) begin
            state_d = S_FINISH;
          end else begin
            go_issue = 1'b1;
            tgt_pc   = '0;
            tgt_len  = start_len;
          end
        end
      end
      S_ISSUE: begin
        if (trunc_q) begin
          // mvi with its immediate outside the program: abort.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          wd_d    = '0;
          if (mvi_q) din_d = mem[pc_q + AW'(1)];
        end
      end
      S_WAIT: begin
        if (Done) begin
          if (nxt_pc >= len_q) begin
            state_d = S_FINISH;
          end else begin
            go_issue = 1'b1;
            tgt_pc   = nxt_pc;
            tgt_len  = len_q;
            pc_d     = nxt_pc[AW-1:0];
          end
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (go_issue) begin
      state_d  = S_ISSUE;
      tgt_word = mem[tgt_pc[AW-1:0]];
      tgt_mvi  = (tgt_word[8:6] == OP_MVI);
      mvi_d    = tgt_mvi;
      trunc_d  = tgt_mvi && ((tgt_pc + X_ONE) >= tgt_len);
      din_d    = tgt_word;
    end

    run_d  = go_issue && !trunc_d;
    busy_d = (state_d != S_IDLE);
    fin_d  = (state_d == S_FINISH);
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      wd_q    <= '0;
      mvi_q   <= 1'b0;
      trunc_q <= 1'b0;
      din_q   <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      wd_q    <= wd_d;
      mvi_q   <= mvi_d;
      trunc_q <= trunc_d;
      din_q   <= din_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
    end
  end

  assign DIN      = din_q;
  assign Run      = run_q;
  assign PC       = pc_q;
  assign Busy     = busy_q;
  assign Finished = fin_q;
  assign Error    = err_q;

endmodule

// File: tb/tb_sequenciador_programa.sv
// Bench for sequenciador_programa: directed cases plus random programs,
// checked cycle by cycle against a trace built from the sequencing rules.
module tb_sequenciador_programa;
  localparam int TO   = 7;
  localparam int MAXT = 400;

  logic        Clock = 1'b0;
  logic        Reset, WrEn, Start, Done;
  logic [3:0]  WrAddr;
  logic [15:0] WrData;
  logic [4:0]  ProgLen;
  logic [15:0] DIN;
  logic        Run, Busy, Finished, Error;
  logic [3:0]  PC;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] bm [16];
  int          lat [16];

  bit          e_busy [MAXT];
  bit          e_run  [MAXT];
  bit          e_fin  [MAXT];
  bit          e_err  [MAXT];
  bit          e_dinv [MAXT];
  bit          e_wait [MAXT];
  bit          done_at[MAXT];
  logic [15:0] e_din  [MAXT];
  int          e_pc   [MAXT];
  int          T;

  always #5 Clock = ~Clock;

  sequenciador_programa dut (
    .Clock(Clock), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .ProgLen(ProgLen), .Start(Start), .Done(Done),
    .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy), .Finished(Finished),
    .Error(Error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected observation trace (one entry per cycle after the Start edge),
  // derived from program contents, ProgLen and the processor latencies.
  task automatic build(input int len);
    int t, pc, k, L, nw, np;
    bit mvi, err, stop;
    logic [15:0] w, ww;
    for (int c = 0; c < MAXT; c++) begin
      e_busy[c] = 0; e_run[c] = 0; e_fin[c] = 0; e_err[c] = 0;
      e_dinv[c] = 0; e_wait[c] = 0; done_at[c] = 0; e_din[c] = '0; e_pc[c] = 0;
    end
    t = 0; pc = 0; k = 0; err = 0; stop = 0;
    if (len == 0) begin
      e_busy[0] = 1; e_fin[0] = 1; T = 1; stop = 1;
    end
    while (!stop) begin
      w   = bm[pc];
      mvi = (w[8:6] == 3'b001);
      e_busy[t] = 1; e_pc[t] = pc; e_din[t] = w; e_dinv[t] = 1;
      if (mvi && (pc + 1 >= len)) begin
        err = 1; T = t + 1; stop = 1;
      end else begin
        e_run[t] = 1;
        ww = mvi ? bm[pc + 1] : w;
        L  = lat[k];
        nw = (L > TO) ? TO : L;
        for (int i = 1; i <= nw; i++) begin
          e_busy[t+i] = 1; e_wait[t+i] = 1; e_pc[t+i] = pc;
          e_din[t+i] = ww; e_dinv[t+i] = 1;
        end
        if (L > TO) begin
          err = 1; T = t + TO + 1; stop = 1;
        end else begin
          done_at[t+L] = 1;
          np = pc + (mvi ? 2 : 1);
          if (np >= len) begin
            e_busy[t+L+1] = 1; e_fin[t+L+1] = 1; e_pc[t+L+1] = pc;
            T = t + L + 2; stop = 1;
          end else begin
            pc = np; t = t + L + 1; k++;
          end
        end
      end
    end
    for (int c = T; c < T + 2; c++) begin
      e_err[c] = err; e_pc[c] = pc;
    end
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      WrEn = 1'b1; WrAddr = 4'(i); WrData = bm[i];
    end
    @(negedge Clock);
    WrEn = 1'b0;
  endtask

  // One run: pulse Start, act as the processor (Done per the latency table),
  // optionally inject ignored Start/WrEn/Done/ProgLen noise, check each cycle.
  task automatic exec_run(input int len, input bit noise, input string name);
    build(len);
    @(negedge Clock);
    Start = 1'b1; ProgLen = 5'(len); Done = 1'b0; WrEn = 1'b0;
    for (int c = 0; c < T + 2; c++) begin
      @(negedge Clock);
      chk($sformatf("%s.busy@%0d", name, c), 32'(Busy), 32'(e_busy[c]));
      chk($sformatf("%s.run@%0d", name, c), 32'(Run), 32'(e_run[c]));
      chk($sformatf("%s.fin@%0d", name, c), 32'(Finished), 32'(e_fin[c]));
      chk($sformatf("%s.err@%0d", name, c), 32'(Error), 32'(e_err[c]));
      chk($sformatf("%s.pc@%0d", name, c), 32'(PC), 32'(e_pc[c]));
      if (e_dinv[c]) chk($sformatf("%s.din@%0d", name, c), 32'(DIN), 32'(e_din[c]));
      Start  = noise && e_busy[c] && ($urandom_range(0, 3) == 0);
      WrEn   = noise && e_busy[c] && ($urandom_range(0, 3) == 0);
      WrAddr = 4'($urandom);
      WrData = 16'($urandom);
      Done   = done_at[c] || (noise && !e_wait[c] && ($urandom_range(0, 3) == 0));
      if (noise) ProgLen = 5'($urandom);
    end
    Start = 1'b0; WrEn = 1'b0; Done = 1'b0;
  endtask

  initial begin
    int len;
    bit noise;
    logic [15:0] w;
    Reset = 1'b1; WrEn = 1'b0; Start = 1'b0; Done = 1'b0;
    WrAddr = '0; WrData = '0; ProgLen = '0;
    #1;
    chk("reset.din", 32'(DIN), 32'(0));
    chk("reset.run", 32'(Run), 32'(0));
    chk("reset.pc", 32'(PC), 32'(0));
    chk("reset.busy", 32'(Busy), 32'(0));
    chk("reset.fin", 32'(Finished), 32'(0));
    chk("reset.err", 32'(Error), 32'(0));
    @(negedge Clock); @(negedge Clock);
    Reset = 1'b0;

    // single add
    bm[0] = 16'h0088; load(1);
    lat[0] = 2; exec_run(1, 0, "add");

    // mixed: mvi R1,#5 ; mv R2,R1
    bm[0] = 16'h0048; bm[1] = 16'h0005; bm[2] = 16'h0011; load(3);
    lat[0] = 3; lat[1] = 2; exec_run(3, 0, "mixed");

    // truncated mvi
    bm[0] = 16'h0048; load(1);
    exec_run(1, 0, "trunc");

    // watchdog expiry, then Done exactly on the last allowed cycle
    bm[0] = 16'h0088; load(1);
    lat[0] = 20; exec_run(1, 0, "timeout");
    lat[0] = TO; exec_run(1, 0, "done_at_limit");

    // empty program, with noise
    exec_run(0, 1, "empty");

    // ignored Start/WrEn/Done mid-run, then a clean rerun to show buffer intact
    bm[0] = 16'h0048; bm[1] = 16'h0005; bm[2] = 16'h0011; load(3);
    lat[0] = 4; lat[1] = 3; exec_run(3, 1, "noise");
    lat[0] = 1; lat[1] = 1; exec_run(3, 0, "after_noise");

    // full buffer: PC steps to DEPTH without wrapping
    for (int i = 0; i < 16; i++) begin bm[i] = 16'h0088 + 16'(i); lat[i] = 1; end
    load(16);
    exec_run(16, 0, "full");

    // mid-run reset while waiting on the second instruction
    bm[0] = 16'h0048; bm[1] = 16'h0005; bm[2] = 16'h0011; load(3);
    @(negedge Clock); Start = 1'b1; ProgLen = 5'd3;
    @(negedge Clock); Start = 1'b0; Done = 1'b0;       // ISSUE mvi
    @(negedge Clock); Done = 1'b1;                     // WAIT 1, Done
    @(negedge Clock); Done = 1'b0;                     // ISSUE mv
    chk("midrst.run_pre", 32'(Run), 32'(1));
    @(negedge Clock); @(negedge Clock);                // WAIT 1, 2
    chk("midrst.pc_pre", 32'(PC), 32'(2));
    #2 Reset = 1'b1;
    #1;
    chk("midrst.din", 32'(DIN), 32'(0));
    chk("midrst.run", 32'(Run), 32'(0));
    chk("midrst.pc", 32'(PC), 32'(0));
    chk("midrst.busy", 32'(Busy), 32'(0));
    chk("midrst.fin", 32'(Finished), 32'(0));
    chk("midrst.err", 32'(Error), 32'(0));
    @(negedge Clock); Reset = 1'b0;
    lat[0] = 2; lat[1] = 2; exec_run(3, 0, "after_rst");

    // random programs
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 16; i++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w[8:6] = 3'b001;
        bm[i]  = w;
        lat[i] = ($urandom_range(0, 19) == 0) ? 9 : int'($urandom_range(1, TO));
      end
      load(16);
      len   = int'($urandom_range(0, 16));
      noise = 1'($urandom_range(0, 1));
      exec_run(len, noise, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sequenciador_programa.md
# sequenciador_programa

Program sequencer that acts as the instruction source for the multicycle processor. It stores a short program of 16-bit words in a local buffer. On command it drives the processor's `DIN`/`Run` inputs one instruction at a time and waits for the processor's `Done` before issuing the next instruction. For `mvi` it supplies the immediate word in the cycle after issue; a watchdog aborts the run if `Done` never arrives.

## Interface
- `DEPTH`, 16, number of 16-bit words in the program buffer.
- `AW`, 4, address width; `2**AW == DEPTH`.
- `TIMEOUT`, 7, maximum cycles spent in WAIT without `Done` before abort.

- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `WrEn` in 1: buffer write strobe.
- `WrAddr` in AW: buffer write address.
- `WrData` in 16: buffer write data.
- `ProgLen` in AW+1: number of words in the program (0..DEPTH); sampled on an accepted `Start`.
- `Start` in 1: run request, single-cycle pulse.
- `Done` in 1: instruction-complete flag from the processor.
- `DIN` out 16: word presented to the processor.
- `Run` out 1: issue strobe to the processor.
- `PC` out AW: address of the current instruction.
- `Busy` out 1: high while a program is executing.
- `Finished` out 1: one-cycle pulse on normal completion.
- `Error` out 1: sticky abort flag.

## Operation
- **Instruction format**
  - Opcode is `DIN[8:6]`.
  - Opcode `001` (`mvi`) is a two-word instruction; the next buffer word is the immediate.
  - All other opcodes are one word.
- **Buffer writes**
  - Writes are accepted only in IDLE.
  - `WrEn` while `Busy` is ignored.
  - The buffer is not cleared by reset.
- **States: IDLE, ISSUE, WAIT, FINISH.**
- **IDLE**
  - `Start` is accepted: latch `ProgLen`, set `PC=0`, clear `Error`.
  - If `ProgLen==0`, go to FINISH; otherwise go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `DIN = mem[PC]`, `Run = 1`.
  - If the opcode is `mvi` and `PC+1 >= ProgLen`: set `Error`, go to IDLE. In this case `Run` is 0 in this cycle.
  - Otherwise go to WAIT and clear the watchdog.
- **WAIT**
  - `Run = 0`.
  - `DIN = mem[PC+1]` for `mvi`, `mem[PC]` otherwise. The value is held stable until `Done`.
  - On `Done`: advance `PC` by 2 (`mvi`) or 1. If the new `PC >= ProgLen`, go to FINISH; otherwise go to ISSUE.
  - If the watchdog reaches `TIMEOUT` without `Done`: set `Error`, go to IDLE.
- **FINISH**
  - `Finished = 1` for one cycle, then go to IDLE.
- **PC arithmetic**
  - The next-PC compare is done at width AW+1, so `PC` reaching `DEPTH` is detected and does not wrap.
  - The `PC` output holds the last valid address.
- **Ignored inputs**
  - `Start` in any state other than IDLE.
  - `Done` in IDLE, ISSUE and FINISH.

## Timing
- **Reset values:** state IDLE, `DIN=0`, `Run=0`, `PC=0`, `Busy=0`, `Finished=0`, `Error=0`.
- **Mid-run reset:** asserting reset at any point returns these values immediately (asynchronously). The processor is expected to be reset in the same event.
- **Start to issue:** `Start` is sampled at edge k; ISSUE occupies cycle k+1, so `Run` is high between edges k+1 and k+2.
- **Issue to WAIT:** the immediate word appears on `DIN` in cycle k+2, which the processor consumes in its T1.
- **Done to next issue:** `Done` sampled at edge n in WAIT puts the next ISSUE in cycle n+1. Minimum spacing between `Run` pulses is therefore 2 cycles plus the processor latency.
- **Outputs:** `Busy` is 1 in ISSUE, WAIT and FINISH. All outputs are registered or decoded from state only; there is no combinational path from `Done` to `Run`.
- **Watchdog:** counts WAIT cycles 1..`TIMEOUT`. `Done` arriving in the same cycle as the count reaching `TIMEOUT` wins; no `Error` is raised.
- **Error:** once set, stays set until the next accepted `Start` or reset.

## Test plan
- **Single add:** load `mem[0]=0x0088` (add), `ProgLen=1`, pulse `Start`, model returns `Done` 2 cycles after `Run` -> exactly one `Run` pulse with `DIN=0x0088`, `Finished` pulse, `Error=0`.
- **Mixed program:** `mvi R1,#5` (`0x0048`, `0x0005`) then `mv R2,R1` (`0x0011`), `ProgLen=3` -> `DIN` goes `0x0048`, `0x0005` (held until `Done`), then `0x0011`; `Run` pulses twice; `PC` steps 0 -> 2; `Finished` pulses.
- **Truncated mvi:** `mvi` as the last word with `ProgLen=1` -> no `Run` pulse, `Error=1`, return to IDLE, no `Finished`.
- **Timeout:** `Done` never asserted -> `Error` rises after 7 WAIT cycles. `Done` exactly on cycle 7 -> no `Error`.
- **Ignored inputs:** `ProgLen=0` gives `Finished` one cycle after `Start` with no `Run`. `Start` and `WrEn` pulsed mid-run are ignored and the buffer contents are unchanged.
- **Mid-run reset:** reset during WAIT -> all outputs 0 at once. A new `Start` afterwards runs the program from `PC=0`.
